// File: rtl/cmplx_mul_seq.sv
// Signed complex multiplier sequencer: time-shares one external unsigned 16x16
// multiplier over four cycles and accumulates re = ar*br - ai*bi, im = ar*bi + ai*br.
//
// state | meaning
// IDLE  | ready for operands, magnitudes/signs captured on in_valid
// MUL0  | |ar|*|br| -> acc_re
// MUL1  | |ai|*|bi| subtracted from acc_re
// MUL2  | |ar|*|bi| -> acc_im
// MUL3  | |ai|*|br| added to acc_im
// DONE  | result presented, held until out_ready
module cmplx_mul_seq #(
    parameter int W  = 16,
    parameter int OW = 2*W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  ar,
    input  logic signed [W-1:0]  ai,
    input  logic signed [W-1:0]  br,
    input  logic signed [W-1:0]  bi,
    output logic [W-1:0]         mul_a,
    output logic [W-1:0]         mul_b,
    input  logic [2*W-1:0]       mul_p,
    output logic                 mul_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] re,
    output logic signed [OW-1:0] im,
    output logic                 busy
);

    typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, DONE} state_t;

    state_t state, state_nxt;

    logic [W-1:0]         mag_ar, mag_ai, mag_br, mag_bi;
    logic                 sgn_ar, sgn_ai, sgn_br, sgn_bi;
    logic signed [OW-1:0] acc_re, acc_im;
    logic                 neg;
    logic signed [OW-1:0] prod;
    logic signed [OW-1:0] term;

    // |-32768| fits as 16'h8000 because the magnitude is treated as unsigned
    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? (~x + W'(1)) : x;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mul_a     = '0;
        mul_b     = '0;
        mul_en    = 1'b0;
        neg       = 1'b0;
        case (state)
            IDLE: if (in_valid) state_nxt = MUL0;
            MUL0: begin
                mul_a = mag_ar; mul_b = mag_br; neg = sgn_ar ^ sgn_br;
                mul_en = 1'b1; state_nxt = MUL1;
            end
            MUL1: begin
                mul_a = mag_ai; mul_b = mag_bi; neg = sgn_ai ^ sgn_bi;
                mul_en = 1'b1; state_nxt = MUL2;
            end
            MUL2: begin
                mul_a = mag_ar; mul_b = mag_bi; neg = sgn_ar ^ sgn_bi;
                mul_en = 1'b1; state_nxt = MUL3;
            end
            MUL3: begin
                mul_a = mag_ai; mul_b = mag_br; neg = sgn_ai ^ sgn_br;
                mul_en = 1'b1; state_nxt = DONE;
            end
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // negating a zero product yields zero, so no sign artifact reaches the sum
    assign prod = {1'b0, mul_p};
    assign term = neg ? -prod : prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_ar <= '0; mag_ai <= '0; mag_br <= '0; mag_bi <= '0;
            sgn_ar <= 1'b0; sgn_ai <= 1'b0; sgn_br <= 1'b0; sgn_bi <= 1'b0;
            acc_re <= '0;
            acc_im <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    mag_ar <= mag(ar); mag_ai <= mag(ai);
                    mag_br <= mag(br); mag_bi <= mag(bi);
                    sgn_ar <= ar[W-1]; sgn_ai <= ai[W-1];
                    sgn_br <= br[W-1]; sgn_bi <= bi[W-1];
                end
                MUL0: acc_re <= term;
                MUL1: acc_re <= acc_re - term;
                MUL2: acc_im <= term;
                MUL3: acc_im <= acc_im + term;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign re        = acc_re;
    assign im        = acc_im;

endmodule

// File: tb/tb_cmplx_mul_seq.sv
// Directed bench for cmplx_mul_seq; the shared multiplier is modelled as a plain
// unsigned product of mul_a and mul_b.
module tb_cmplx_mul_seq;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] ar, ai, br, bi;
    logic [15:0]        mul_a, mul_b;
    logic [31:0]        mul_p;
    logic               mul_en;
    logic               out_valid;
    logic               out_ready;
    logic signed [32:0] re, im;
    logic               busy;

    int checks = 0;
    int errors = 0;

    cmplx_mul_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ar(ar), .ai(ai), .br(br), .bi(bi),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .mul_en(mul_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .re(re), .im(im), .busy(busy)
    );

    assign mul_p = {16'b0, mul_a} * {16'b0, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] absval(input logic signed [15:0] x);
        int v;
        v = int'(x);
        if (v < 0) v = -v;
        return 16'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a job from IDLE, checks the multiplier schedule, latency and result; ends in DONE.
    task automatic do_job(input logic signed [15:0] xar, xai, xbr, xbi,
                          input logic signed [32:0] exp_re, exp_im, input string name);
        logic [15:0] ea [4];
        logic [15:0] eb [4];
        ea[0] = absval(xar); eb[0] = absval(xbr);
        ea[1] = absval(xai); eb[1] = absval(xbi);
        ea[2] = absval(xar); eb[2] = absval(xbi);
        ea[3] = absval(xai); eb[3] = absval(xbr);
        ar = xar; ai = xai; br = xbr; bi = xbi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b busy=%b required 0/1", name, in_ready, busy);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mul_en !== 1'b1 || mul_a !== ea[k] || mul_b !== eb[k] || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s mul%0d: en=%b a=%h b=%h ov=%b required 1 %h %h 0",
                         name, k, mul_en, mul_a, mul_b, out_valid, ea[k], eb[k]);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || mul_en !== 1'b0 || mul_a !== 16'h0 || mul_b !== 16'h0) begin
            errors++;
            $display("FAIL %s done: ov=%b en=%b a=%h b=%h required 1 0 0 0",
                     name, out_valid, mul_en, mul_a, mul_b);
        end
        checks++;
        if (re !== exp_re || im !== exp_im) begin
            errors++;
            $display("FAIL %s result: re=%0d im=%0d required re=%0d im=%0d",
                     name, re, im, exp_re, exp_im);
        end
    endtask

    task automatic finish_xfer(input string name);
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s return_idle: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     name, in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || mul_en !== 1'b0 ||
            mul_a !== 16'h0 || mul_b !== 16'h0 || re !== 33'sd0 || im !== 33'sd0) begin
            errors++;
            $display("FAIL reset: ir=%b ov=%b busy=%b en=%b a=%h b=%h re=%0d im=%0d required 1 0 0 0 0 0 0 0",
                     in_ready, out_valid, busy, mul_en, mul_a, mul_b, re, im);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        do_job(16'sd3, 16'sd4, 16'sd5, 16'sd6, -33'sd9, 33'sd38, "basic");
        finish_xfer("basic");
    endtask

    task automatic test_extreme();
        do_job(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768,
               33'sd0, 33'sh0_8000_0000, "extreme");
        finish_xfer("extreme");
    endtask

    task automatic test_mixed_zero();
        do_job(-16'sd7, 16'sd0, 16'sd2, -16'sd3, -33'sd14, 33'sd21, "mixed_zero");
        finish_xfer("mixed_zero");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        do_job(16'sd1, 16'sd2, 16'sd3, 16'sd4, -33'sd5, 33'sd10, "bp_first");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            ar = 16'(i * 37 - 100); ai = 16'(i * 11); br = 16'(-i); bi = 16'(i + 9);
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || re !== -33'sd5 || im !== 33'sd10) begin
                errors++;
                $display("FAIL bp_hold%0d: ov=%b ir=%b re=%0d im=%0d required 1 0 -5 10",
                         i, out_valid, in_ready, re, im);
            end
        end
        ar = 16'sd5; ai = 16'sd6; br = 16'sd7; bi = 16'sd8;
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        do_job(16'sd5, 16'sd6, 16'sd7, 16'sd8, -33'sd13, 33'sd82, "bp_second");
        finish_xfer("bp_second");
    endtask

    task automatic test_reset_midop();
        ar = 16'sd3; ai = 16'sd4; br = 16'sd5; bi = 16'sd6;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (mul_en !== 1'b1 || mul_a !== 16'd3 || mul_b !== 16'd6) begin
            errors++;
            $display("FAIL midop_in_mul2: en=%b a=%0d b=%0d required 1 3 6", mul_en, mul_a, mul_b);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || re !== 33'sd0 || im !== 33'sd0 ||
            mul_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midop_abort: ir=%b ov=%b re=%0d im=%0d en=%b busy=%b required 1 0 0 0 0 0",
                     in_ready, out_valid, re, im, mul_en, busy);
        end
        do_job(16'sd1, 16'sd1, 16'sd1, -16'sd1, 33'sd2, 33'sd0, "after_reset");
        finish_xfer("after_reset");
    endtask

    task automatic test_back_to_back();
        logic signed [15:0] s_ar [3];
        logic signed [15:0] s_ai [3];
        logic signed [15:0] s_br [3];
        logic signed [15:0] s_bi [3];
        longint g_re, g_im;
        int     acc_cyc [3];
        int     nacc, nres;
        logic   take_in, take_out;
        s_ar[0] = 16'sd100;    s_ai[0] = -16'sd200;  s_br[0] = 16'sd300; s_bi[0] = -16'sd400;
        s_ar[1] = -16'sd32768; s_ai[1] = 16'sd32767; s_br[1] = -16'sd1;  s_bi[1] = 16'sd1;
        s_ar[2] = -16'sd5;     s_ai[2] = -16'sd5;    s_br[2] = -16'sd5;  s_bi[2] = -16'sd5;
        nacc = 0;
        nres = 0;
        out_ready = 1'b1;
        ar = s_ar[0]; ai = s_ai[0]; br = s_br[0]; bi = s_bi[0];
        in_valid = 1'b1;
        for (int c = 0; c < 60 && nres < 3; c++) begin
            take_in  = in_ready && in_valid;
            take_out = out_valid && out_ready;
            if (take_out) begin
                g_re = longint'(s_ar[nres]) * longint'(s_br[nres]) - longint'(s_ai[nres]) * longint'(s_bi[nres]);
                g_im = longint'(s_ar[nres]) * longint'(s_bi[nres]) + longint'(s_ai[nres]) * longint'(s_br[nres]);
                checks++;
                if (re !== 33'(g_re) || im !== 33'(g_im)) begin
                    errors++;
                    $display("FAIL b2b_result%0d: re=%0d im=%0d required re=%0d im=%0d",
                             nres, re, im, g_re, g_im);
                end
                nres++;
            end
            tick();
            if (take_in) begin
                acc_cyc[nacc] = c;
                nacc++;
                if (nacc < 3) begin
                    ar = s_ar[nacc]; ai = s_ai[nacc]; br = s_br[nacc]; bi = s_bi[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (nacc !== 3 || nres !== 3) begin
            errors++;
            $display("FAIL b2b_count: accepted=%0d results=%0d required 3 3", nacc, nres);
        end else begin
            checks++;
            if (acc_cyc[1] - acc_cyc[0] !== 6 || acc_cyc[2] - acc_cyc[1] !== 6) begin
                errors++;
                $display("FAIL b2b_interval: gaps=%0d,%0d required 6,6",
                         acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        ar = '0; ai = '0; br = '0; bi = '0;
        test_reset();
        test_basic();
        test_extreme();
        test_mixed_zero();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmplx_mul_seq.md
Name: cmplx_mul_seq

Overview:
- Sequencer that time-shares one unsigned 16x16 Vedic multiplier (vedic16: 16-bit a/b in, 32-bit product out, purely combinational) to compute a signed complex product (ar + j·ai)·(br + j·bi).
- Issues the four partial products over four consecutive cycles, handling sign-magnitude conversion and accumulation.
- Sits between the complex-multiplier front end (valid/ready operand stream) and the shared multiplier instance; the result leaves on a valid/ready stream.

Parameters:
- W, 16, operand width. Only 16 is supported, to match the multiplier.
- OW, 33, result width per component (2·W+1). Fixed, so no overflow is possible.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands
- ar, ai, br, bi  input  16 each  signed two's-complement operands
- mul_a  output  16  unsigned magnitude to the multiplier port a
- mul_b  output  16  unsigned magnitude to the multiplier port b
- mul_p  input  32  unsigned product from the multiplier; combinational in mul_a/mul_b
- mul_en  output  1  high while a multiply state is active
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- re, im  output  33 each  signed result: re = ar·br − ai·bi, im = ar·bi + ai·br
- busy  output  1  state ≠ IDLE

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - in_ready = 1, out_valid = 0, busy = 0, mul_en = 0.
  - mul_a = mul_b = 0, re = im = 0.
  - Magnitude, sign and accumulator registers = 0.
- States: IDLE → MUL0 → MUL1 → MUL2 → MUL3 → DONE → IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid=1 at an edge: register |ar|, |ai|, |br|, |bi| as 16-bit unsigned (|−32768| = 32768 = 16'h8000) and their four sign bits; go to MUL0.
  - With in_valid=0: stay in IDLE.
- MULk pairs, with mul_a/mul_b driven combinationally from state and the magnitude registers:
  - MUL0: |ar|·|br|
  - MUL1: |ai|·|bi|
  - MUL2: |ar|·|bi|
  - MUL3: |ai|·|br|
- mul_a, mul_b and mul_en are 0 outside MUL states.
- Signed term: t = mul_p zero-extended to 33 bits, negated when the XOR of the two operand sign bits is 1. A zero product stays 0 whatever the signs.
- Accumulation, captured at the end-of-state edge:
  - MUL0: acc_re ← t
  - MUL1: acc_re ← acc_re − t
  - MUL2: acc_im ← t
  - MUL3: acc_im ← acc_im + t; go to DONE.
- DONE:
  - out_valid = 1; re/im = acc_re/acc_im, held stable while out_ready = 0.
  - Transfer occurs at an edge with out_valid & out_ready; next state IDLE.
- Timing:
  - Latency: out_valid rises 5 cycles after the accepting edge.
  - Minimum initiation interval: 6 cycles.
- in_ready = 0 in every state except IDLE. in_valid and operand changes outside IDLE are ignored; the captured operands are used unchanged.
- Reset mid-operation (any state): abort and discard. The next cycle is IDLE with all outputs at reset values; no partial result is emitted.
- The sequencer never overlaps jobs; the multiplier is used by at most one term per cycle.

Test Plan:
1. Basic: ar=3, ai=4, br=5, bi=6, in_valid for 1 cycle.
   - in_ready drops next cycle.
   - mul_a/mul_b sequence is (3,5), (4,6), (3,6), (4,5).
   - out_valid 5 cycles after acceptance with re=−9, im=38.
   - Returns to IDLE after out_ready.
2. Extreme: ar=ai=br=bi=−32768.
   - mul_a = mul_b = 16'h8000 in every MUL state.
   - re = 0, im = 2147483648 (33'h0_8000_0000), with no wrap.
3. Mixed signs / zero: ar=−7, ai=0, br=2, bi=−3.
   - re = −14, im = 21.
   - The zero term contributes 0 (no −0 artifact).
4. Backpressure: out_ready held 0 for 10 cycles in DONE, with in_valid=1 and operands changing throughout.
   - out_valid stays 1; re/im stay stable; in_ready stays 0; the second job is not accepted.
   - When out_ready=1, the result transfers; the next operands are accepted on the following IDLE edge.
5. Reset mid-op: rst=1 for one cycle while in MUL2.
   - Next cycle: IDLE, in_ready=1, out_valid=0, re=im=0, mul_en=0.
   - A fresh job (1+1j)·(1−1j) yields re=2, im=0.
6. Back-to-back: in_valid held high with 3 different operand sets.
   - Each is accepted exactly 6 cycles apart (out_ready tied 1).
   - Results match a golden model in order.
